// File: rtl/sl_channel_scheduler.sv
// rtl/sl_channel_scheduler.sv - round-robin endpoint scheduler with sticky pending flags and service watchdog
module sl_channel_scheduler #(
    parameter int CHANNEL_COUNT  = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CHANNEL_COUNT-1:0]   tx_event,
    input  logic [CHANNEL_COUNT-1:0]   rx_event,
    input  logic                       mask_we,
    input  logic [2*CHANNEL_COUNT-1:0] mask_data,
    output logic                       grant_valid,
    output logic [5:0]                 grant_addr,
    input  logic                       grant_ready,
    input  logic                       service_done,
    output logic [2*CHANNEL_COUNT-1:0] pending,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int N  = 2 * CHANNEL_COUNT;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OFFER,
        ST_SERVICE
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        pending_q, pending_d;
    logic [N-1:0]        mask_q, mask_d;
    logic [N-1:0]        set_vec, clr_vec, eligible;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       winner, granted, ptr_after;
    logic [PW:0]         idx;
    logic                any_eligible;
    logic [5:0]          addr_q, addr_d;
    logic                valid_q, valid_d;
    logic                to_q, to_d;
    logic                handshake;
    logic [TO_WIDTH-1:0] wd_q, wd_d;

    // Endpoint s = 2*ch + is_rec: tx events land on even bits, rx on odd bits
    for (genvar g = 0; g < CHANNEL_COUNT; g++) begin : g_set
        assign set_vec[2*g]   = tx_event[g];
        assign set_vec[2*g+1] = rx_event[g];
    end

    assign eligible  = pending_q & ~mask_q;
    assign granted   = addr_q[PW-1:0];
    assign ptr_after = (granted == PW'(N - 1)) ? '0 : granted + 1'b1;
    assign handshake = (state_q == ST_OFFER) && valid_q && grant_ready;

    // Scan offsets from high to low so the smallest offset from the pointer wins
    always_comb begin
        winner       = '0;
        any_eligible = 1'b0;
        idx          = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + (PW + 1)'(i);
            if (idx >= (PW + 1)'(N)) begin
                idx = idx - (PW + 1)'(N);
            end
            if (eligible[idx[PW-1:0]]) begin
                winner       = idx[PW-1:0];
                any_eligible = 1'b1;
            end
        end
    end

    always_comb begin
        clr_vec = '0;
        if (handshake) begin
            clr_vec[granted] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        to_d      = 1'b0;
        mask_d    = mask_we ? mask_data : mask_q;
        // Set after clear so an event coincident with its grant is kept
        pending_d = (pending_q & ~clr_vec) | set_vec;

        case (state_q)
            ST_IDLE: begin
                if (any_eligible) begin
                    addr_d  = 6'(winner);
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (handshake) begin
                    valid_d = 1'b0;
                    wd_d    = TO_WIDTH'(TIMEOUT_CYCLES);
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (service_done) begin
                    ptr_d   = ptr_after;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd_q - 1'b1;
                    if (wd_q == TO_WIDTH'(1)) begin
                        to_d    = 1'b1;
                        ptr_d   = ptr_after;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            mask_q    <= '0;
            ptr_q     <= '0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            to_q      <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            to_q      <= to_d;
            wd_q      <= wd_d;
        end
    end

    assign grant_valid = valid_q;
    assign grant_addr  = addr_q;
    assign pending     = pending_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = to_q;

endmodule

// File: tb/tb_sl_channel_scheduler.sv
// tb/tb_sl_channel_scheduler.sv - self-checking bench for sl_channel_scheduler
module tb_sl_channel_scheduler;

    localparam int CC = 2;
    localparam int N  = 2 * CC;
    localparam int T  = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CC-1:0] tx_event = '0;
    logic [CC-1:0] rx_event = '0;
    logic          mask_we = 1'b0;
    logic [N-1:0]  mask_data = '0;
    logic          grant_valid;
    logic [5:0]    grant_addr;
    logic          grant_ready = 1'b0;
    logic          service_done = 1'b0;
    logic [N-1:0]  pending;
    logic          busy;
    logic          timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    sl_channel_scheduler #(
        .CHANNEL_COUNT (CC),
        .TIMEOUT_CYCLES(T),
        .TO_WIDTH      (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_event    (tx_event),
        .rx_event    (rx_event),
        .mask_we     (mask_we),
        .mask_data   (mask_data),
        .grant_valid (grant_valid),
        .grant_addr  (grant_addr),
        .grant_ready (grant_ready),
        .service_done(service_done),
        .pending     (pending),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 offering, 2 servicing; cnt counts service cycles
    typedef struct packed {
        logic [1:0]   phase;
        logic [5:0]   addr;
        logic         valid;
        logic [5:0]   ptr;
        logic [15:0]  cnt;
        logic         to;
        logic [N-1:0] pend;
        logic [N-1:0] mask;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t c, input logic [CC-1:0] tx,
                                          input logic [CC-1:0] rx, input logic mwe,
                                          input logic [N-1:0] md, input logic rdy,
                                          input logic done);
        model_t nx = c;
        nx.to = 1'b0;
        if (c.phase == 2'd0) begin
            for (int i = 0; i < N; i++) begin
                int s = (int'(c.ptr) + i) % N;
                if (c.pend[s] && !c.mask[s]) begin
                    nx.addr  = 6'(s);
                    nx.valid = 1'b1;
                    nx.phase = 2'd1;
                    break;
                end
            end
        end else if (c.phase == 2'd1) begin
            if (rdy) begin
                nx.valid       = 1'b0;
                nx.pend[c.addr] = 1'b0;
                nx.cnt         = '0;
                nx.phase       = 2'd2;
            end
        end else begin
            if (done) begin
                nx.phase = 2'd0;
                nx.ptr   = 6'((int'(c.addr) + 1) % N);
            end else begin
                nx.cnt = 16'(int'(c.cnt) + 1);
                if (int'(nx.cnt) == T) begin
                    nx.to    = 1'b1;
                    nx.phase = 2'd0;
                    nx.ptr   = 6'((int'(c.addr) + 1) % N);
                end
            end
        end
        for (int ch = 0; ch < CC; ch++) begin
            if (tx[ch]) nx.pend[2*ch] = 1'b1;
            if (rx[ch]) nx.pend[2*ch+1] = 1'b1;
        end
        if (mwe) nx.mask = md;
        return nx;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= model_step(m, tx_event, rx_event, mask_we, mask_data, grant_ready, service_done);
    end

    always @(negedge clk) begin
        check("model grant_valid", int'(grant_valid), int'(m.valid));
        check("model pending", int'(pending), int'(m.pend));
        check("model busy", int'(busy), int'(m.phase != 2'd0));
        check("model timeout_err", int'(timeout_err), int'(m.to));
        if (m.valid) check("model grant_addr", int'(grant_addr), int'(m.addr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tx_event = '0; rx_event = '0; mask_we = 1'b0; mask_data = '0;
        grant_ready = 1'b0; service_done = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!grant_valid && n < 20) begin
            tick();
            n++;
        end
        if (!grant_valid) check({name, " wait for grant_valid"}, 0, 1);
    endtask

    task automatic pulse_done();
        service_done = 1'b1;
        tick();
        service_done = 1'b0;
    endtask

    initial begin
        int n;

        // 1: reset state and a single tx grant
        do_reset();
        check("reset grant_valid", int'(grant_valid), 0);
        check("reset pending", int'(pending), 0);
        check("reset busy", int'(busy), 0);
        check("reset timeout_err", int'(timeout_err), 0);
        tx_event = 2'b01;
        tick();
        tx_event = '0;
        check("t1 pending after event", int'(pending), 1);
        check("t1 no grant yet", int'(grant_valid), 0);
        tick();
        check("t1 grant_valid", int'(grant_valid), 1);
        check("t1 grant_addr", int'(grant_addr), 0);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        check("t1 pending cleared", int'(pending), 0);
        check("t1 busy in service", int'(busy), 1);
        pulse_done();
        check("t1 busy after done", int'(busy), 0);

        // 2: all four endpoints, round-robin order and wrap
        do_reset();
        tx_event = 2'b11; rx_event = 2'b11; grant_ready = 1'b1;
        tick();
        tx_event = '0; rx_event = '0;
        check("t2 pending all", int'(pending), 15);
        for (int k = 0; k < 4; k++) begin
            wait_valid("t2");
            check($sformatf("t2 grant %0d addr", k), int'(grant_addr), k);
            tick();
            tick();
            pulse_done();
        end
        tx_event = 2'b01; rx_event = 2'b10;
        tick();
        tx_event = '0; rx_event = '0;
        wait_valid("t2 wrap");
        check("t2 wrap addr", int'(grant_addr), 0);
        tick();
        grant_ready = 1'b0;
        pulse_done();

        // 3: masked endpoint records pending but is not granted until unmasked
        do_reset();
        mask_we = 1'b1; mask_data = 4'b0010;
        tick();
        mask_we = 1'b0;
        rx_event = 2'b01;
        tick();
        rx_event = '0;
        check("t3 masked pending", int'(pending), 2);
        tick(); tick(); tick();
        check("t3 masked no grant", int'(grant_valid), 0);
        mask_we = 1'b1; mask_data = '0;
        tick();
        mask_we = 1'b0;
        check("t3 grant not before unmask seen", int'(grant_valid), 0);
        tick();
        check("t3 unmasked grant_valid", int'(grant_valid), 1);
        check("t3 unmasked grant_addr", int'(grant_addr), 1);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        pulse_done();

        // 4: watchdog expiry, then next endpoint offered
        do_reset();
        tx_event = 2'b11;
        tick();
        tx_event = '0;
        tick();
        check("t4 first addr", int'(grant_addr), 0);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        n = 0;
        while (!timeout_err && n < T + 5) begin
            tick();
            n++;
        end
        check("t4 timeout latency", n, T);
        tick();
        check("t4 timeout one cycle", int'(timeout_err), 0);
        check("t4 next grant_valid", int'(grant_valid), 1);
        check("t4 next grant_addr", int'(grant_addr), 2);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        pulse_done();

        // 5: event on the granted endpoint coincident with the handshake
        do_reset();
        tx_event = 2'b10;
        tick();
        tx_event = '0;
        tick();
        check("t5 grant_addr", int'(grant_addr), 2);
        grant_ready = 1'b1; tx_event = 2'b10;
        tick();
        grant_ready = 1'b0; tx_event = '0;
        check("t5 pending re-armed", int'(pending), 4);
        check("t5 busy", int'(busy), 1);
        pulse_done();
        tick();
        check("t5 re-offer valid", int'(grant_valid), 1);
        check("t5 re-offer addr", int'(grant_addr), 2);
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        pulse_done();

        // 6: asynchronous reset during service
        do_reset();
        tx_event = 2'b01; rx_event = 2'b11;
        tick();
        tx_event = '0; rx_event = '0;
        tick();
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
        check("t6 pending in service", int'(pending), 10);
        check("t6 busy in service", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async pending", int'(pending), 0);
        check("t6 async busy", int'(busy), 0);
        check("t6 async grant_valid", int'(grant_valid), 0);
        check("t6 async grant_addr", int'(grant_addr), 0);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("t6 no grant after release", int'(grant_valid), 0);
        check("t6 pending after release", int'(pending), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
